// File: rtl/tron_pkg.sv
// Shared constants for the tron display path: screen geometry, coordinate
// widths, player colours and the arbiter state encoding.
package tron_pkg;

    localparam int NUM_PLAYERS = 4;
    localparam int X_W         = 8;
    localparam int Y_W         = 7;
    localparam int COLOUR_W    = 3;
    localparam int SCREEN_W    = 160;
    localparam int SCREEN_H    = 120;

    // Player trail colours and the background used by the clear sweep.
    localparam logic [2:0] COL_P1 = 3'b001;
    localparam logic [2:0] COL_P2 = 3'b010;
    localparam logic [2:0] COL_P3 = 3'b100;
    localparam logic [2:0] COL_P4 = 3'b110;
    localparam logic [2:0] COL_BG = 3'b000;

    // Arbiter state encoding.
    localparam logic [0:0] ST_SCAN  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // Index width for a set of n channels, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/player_draw_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, circularly.
// The request vector is duplicated and shifted right by ptr so that a plain
// lowest-bit priority encoder on the low half yields the offset from ptr.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);

    localparam int SW = PW + 1;

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] shifted;
    logic [N-1:0]   rot;
    logic [SW-1:0]  sum;
    logic           found;

    // Rotate the doubled request vector, priority-encode, then map the offset back.
    always_comb begin
        dbl     = {req, req};
        shifted = dbl >> ptr;
        rot     = shifted[N-1:0];
        found   = 1'b0;
        sum     = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + SW'(i);
            end
        end
        if (sum >= SW'(N)) begin
            sum = sum - SW'(N);
        end
        gnt_idx = sum[PW-1:0];
        any     = |req;
    end

endmodule

// File: rtl/player_draw_arbiter.sv
// Pixel scheduler between the game core and the VGA adapter. Issues one
// registered plot beat per free output slot, rotating over alive on-screen
// players, and on request sweeps the whole screen with the background colour.
// A beat held under plot && !plot_ready is never altered or dropped.
module player_draw_arbiter #(
    parameter int             NUM_PLAYERS = tron_pkg::NUM_PLAYERS,
    parameter int             X_W         = tron_pkg::X_W,
    parameter int             Y_W         = tron_pkg::Y_W,
    parameter int             COLOUR_W    = tron_pkg::COLOUR_W,
    parameter int             SCREEN_W    = tron_pkg::SCREEN_W,
    parameter int             SCREEN_H    = tron_pkg::SCREEN_H,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = COLOUR_W'(tron_pkg::COL_BG),
    parameter int             PW          = tron_pkg::idx_w(NUM_PLAYERS)
) (
    input  logic                              CLOCK_50,
    input  logic                              reset,
    input  logic [NUM_PLAYERS*(X_W+Y_W)-1:0]  pos_flat,
    input  logic [NUM_PLAYERS*COLOUR_W-1:0]   colour_flat,
    input  logic [NUM_PLAYERS-1:0]            alive,
    input  logic                              clear_req,
    input  logic                              plot_ready,
    output logic [X_W-1:0]                    x,
    output logic [Y_W-1:0]                    y,
    output logic [COLOUR_W-1:0]               colour,
    output logic                              plot,
    output logic                              busy,
    output logic [PW-1:0]                     last_player
);

    import tron_pkg::*;

    localparam int PE = X_W + Y_W;

    // Per-player unpacked views of the flat buses.
    logic [X_W-1:0]         px   [NUM_PLAYERS];
    logic [Y_W-1:0]         py   [NUM_PLAYERS];
    logic [COLOUR_W-1:0]    pcol [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] eligible;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
            assign px[gi]       = pos_flat[gi*PE + Y_W +: X_W];
            assign py[gi]       = pos_flat[gi*PE +: Y_W];
            assign pcol[gi]     = colour_flat[gi*COLOUR_W +: COLOUR_W];
            assign eligible[gi] = alive[gi]
                                  && (px[gi] < X_W'(SCREEN_W))
                                  && (py[gi] < Y_W'(SCREEN_H));
        end
    endgenerate

    // Registered state.
    logic [0:0]          state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic                pend_q, pend_d;
    logic [X_W-1:0]      cx_q, cx_d;
    logic [Y_W-1:0]      cy_q, cy_d;
    logic                done_q, done_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [COLOUR_W-1:0] col_q, col_d;
    logic                plot_q, plot_d;
    logic                busy_q, busy_d;
    logic [PW-1:0]       lp_q, lp_d;

    logic          slot_free;
    logic [PW-1:0] gnt_idx;
    logic          any_elig;

    rr_pick #(
        .N  (NUM_PLAYERS),
        .PW (PW)
    ) u_pick (
        .req     (eligible),
        .ptr     (ptr_q),
        .gnt_idx (gnt_idx),
        .any     (any_elig)
    );

    assign slot_free = !plot_q || plot_ready;

    // Next-state logic: player rotation in SCAN, raster sweep in CLEAR.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        pend_d  = pend_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        done_d  = done_q;
        x_d     = x_q;
        y_d     = y_q;
        col_d   = col_q;
        plot_d  = plot_q;
        busy_d  = busy_q;
        lp_d    = lp_q;

        case (state_q)
            ST_SCAN: begin
                if (slot_free) begin
                    if (clear_req || pend_q) begin
                        // Current beat (if any) is accepted; start the sweep next.
                        state_d = ST_CLEAR;
                        busy_d  = 1'b1;
                        cx_d    = '0;
                        cy_d    = '0;
                        done_d  = 1'b0;
                        pend_d  = 1'b0;
                        plot_d  = 1'b0;
                    end else if (any_elig) begin
                        x_d    = px[gnt_idx];
                        y_d    = py[gnt_idx];
                        col_d  = pcol[gnt_idx];
                        plot_d = 1'b1;
                        lp_d   = gnt_idx;
                        ptr_d  = (gnt_idx == PW'(NUM_PLAYERS - 1)) ? '0 : gnt_idx + 1'b1;
                    end else begin
                        plot_d = 1'b0;
                    end
                end else if (clear_req) begin
                    // Stalled beat must finish first; remember the request.
                    pend_d = 1'b1;
                end
            end

            ST_CLEAR: begin
                if (slot_free) begin
                    if (done_q) begin
                        // Final sweep pixel has been accepted.
                        state_d = ST_SCAN;
                        busy_d  = 1'b0;
                        ptr_d   = '0;
                        plot_d  = 1'b0;
                        done_d  = 1'b0;
                    end else begin
                        x_d    = cx_q;
                        y_d    = cy_q;
                        col_d  = BG_COLOUR;
                        plot_d = 1'b1;
                        if (cx_q == X_W'(SCREEN_W - 1)) begin
                            cx_d = '0;
                            if (cy_q == Y_W'(SCREEN_H - 1)) begin
                                cy_d   = '0;
                                done_d = 1'b1;
                            end else begin
                                cy_d = cy_q + 1'b1;
                            end
                        end else begin
                            cx_d = cx_q + 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_SCAN;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= ST_SCAN;
            ptr_q   <= '0;
            pend_q  <= 1'b0;
            cx_q    <= '0;
            cy_q    <= '0;
            done_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            lp_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            pend_q  <= pend_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            done_q  <= done_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
            plot_q  <= plot_d;
            busy_q  <= busy_d;
            lp_q    <= lp_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign colour      = col_q;
    assign plot        = plot_q;
    assign busy        = busy_q;
    assign last_player = lp_q;

endmodule

// File: tb/tb_player_draw_arbiter.sv
// Directed bench for player_draw_arbiter: rotation, skipping, stall hold,
// clear sweep and reset during a sweep.
module tb_player_draw_arbiter;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [59:0] pos_flat;
    logic [11:0] colour_flat;
    logic [3:0]  alive;
    logic        clear_req;
    logic        plot_ready;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic [1:0]  last_player;

    int n_cmp = 0;
    int n_err = 0;

    int px_tab  [4] = '{10, 20, 30, 40};
    int py_tab  [4] = '{5, 6, 7, 8};
    int col_tab [4] = '{1, 2, 4, 6};

    player_draw_arbiter dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .pos_flat    (pos_flat),
        .colour_flat (colour_flat),
        .alive       (alive),
        .clear_req   (clear_req),
        .plot_ready  (plot_ready),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .plot        (plot),
        .busy        (busy),
        .last_player (last_player)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_pos(input int i, input int px, input int py);
        pos_flat[i*15 +: 15] = {8'(px), 7'(py)};
    endtask

    task automatic expect_beat(input string tag, input int p, input int ex, input int ey, input int ec);
        chk({tag, ".plot"},   32'(plot), 1);
        chk({tag, ".player"}, 32'(last_player), p);
        chk({tag, ".x"},      32'(x), ex);
        chk({tag, ".y"},      32'(y), ey);
        chk({tag, ".colour"}, 32'(colour), ec);
        $display("%s: player=%0d x=%0d y=%0d colour=%0d busy=%0d", tag, last_player, x, y, colour, busy);
    endtask

    task automatic expect_idle(input string tag, input int eb);
        chk({tag, ".plot"}, 32'(plot), 0);
        chk({tag, ".busy"}, 32'(busy), eb);
        $display("%s: plot=%0d busy=%0d", tag, plot, busy);
    endtask

    initial begin
        int order2 [4] = '{3, 1, 3, 1};
        int order3 [5] = '{3, 0, 1, 3, 0};

        reset       = 1'b1;
        pos_flat    = '0;
        colour_flat = '0;
        alive       = 4'b0000;
        clear_req   = 1'b0;
        plot_ready  = 1'b1;
        step();
        step();
        chk("reset.plot",   32'(plot), 0);
        chk("reset.busy",   32'(busy), 0);
        chk("reset.x",      32'(x), 0);
        chk("reset.y",      32'(y), 0);
        chk("reset.colour", 32'(colour), 0);
        chk("reset.player", 32'(last_player), 0);
        $display("reset: plot=%0d busy=%0d", plot, busy);

        // 1: all four players rotate, one beat per clock.
        for (int i = 0; i < 4; i++) begin
            set_pos(i, px_tab[i], py_tab[i]);
            colour_flat[i*3 +: 3] = 3'(col_tab[i]);
        end
        alive = 4'b1111;
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            expect_beat("rot", k % 4, px_tab[k % 4], py_tab[k % 4], col_tab[k % 4]);
        end

        // 2: only p1,p3 alive (ptr=2 here), then nobody alive.
        alive = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            step();
            expect_beat("alt", order2[k], px_tab[order2[k]], py_tab[order2[k]], col_tab[order2[k]]);
        end
        alive = 4'b0000;
        step();
        expect_idle("none0", 0);
        step();
        expect_idle("none1", 0);
        alive = 4'b1111;
        step();
        expect_beat("ptr_hold", 2, 30, 7, 4);

        // 3: p2 off-screen at x=160 is skipped.
        set_pos(2, 160, 7);
        for (int k = 0; k < 5; k++) begin
            step();
            expect_beat("offscr", order3[k], px_tab[order3[k]], py_tab[order3[k]], col_tab[order3[k]]);
        end
        set_pos(2, 30, 7);

        // 4: stall on p1's beat while p1 moves.
        step();
        expect_beat("pre_stall", 1, 20, 6, 2);
        plot_ready = 1'b0;
        set_pos(1, 99, 50);
        for (int k = 0; k < 5; k++) begin
            step();
            expect_beat("stall", 1, 20, 6, 2);
        end
        plot_ready = 1'b1;
        step();
        expect_beat("post_stall", 2, 30, 7, 4);

        // 5: clear requested during a stall; stalled beat completes first.
        plot_ready = 1'b0;
        clear_req  = 1'b1;
        step();
        clear_req = 1'b0;
        step();
        expect_beat("clr_stall", 2, 30, 7, 4);
        chk("clr_stall.busy", 32'(busy), 0);
        plot_ready = 1'b1;
        step();
        expect_idle("clr_entry", 1);
        for (int k = 0; k < 19200; k++) begin
            if (k == 50) clear_req = 1'b1;
            step();
            clear_req = 1'b0;
            chk("sweep.plot",   32'(plot), 1);
            chk("sweep.busy",   32'(busy), 1);
            chk("sweep.x",      32'(x), k % 160);
            chk("sweep.y",      32'(y), k / 160);
            chk("sweep.colour", 32'(colour), 0);
        end
        $display("sweep: 19200 beats, last at x=%0d y=%0d", x, y);
        step();
        expect_idle("clr_exit", 0);
        step();
        expect_beat("scan_restart", 0, 10, 5, 1);

        // 6: reset at sweep beat 100.
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        expect_idle("clr2_entry", 1);
        for (int k = 0; k < 100; k++) begin
            step();
            chk("sweep2.x", 32'(x), k);
            chk("sweep2.y", 32'(y), 0);
        end
        reset = 1'b1;
        step();
        expect_idle("rst_sweep", 0);
        chk("rst_sweep.x", 32'(x), 0);
        reset = 1'b0;
        step();
        expect_beat("after_rst", 0, 10, 5, 1);
        step();
        expect_beat("after_rst2", 1, 99, 50, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
